// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - CPU/loader arbiter for the single-port data RAM (optional MEM_ARBITER_PERF_COUNTER_EN)
module mem_arbiter #(
   parameter int ADDR_WIDTH = 15,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  cpu_req,
   input  logic                  cpu_we,
   input  logic [ADDR_WIDTH-1:0] cpu_address,
   input  logic [DATA_WIDTH-1:0] cpu_write_data,
   output logic                  cpu_ack,
   output logic [DATA_WIDTH-1:0] cpu_read_data,
   output logic                  cpu_stall,
   input  logic                  ldr_req,
   input  logic                  ldr_we,
   input  logic [ADDR_WIDTH-1:0] ldr_address,
   input  logic [DATA_WIDTH-1:0] ldr_write_data,
   output logic                  ldr_ack,
   output logic [DATA_WIDTH-1:0] ldr_read_data,
   output logic [ADDR_WIDTH-1:0] ram_address,
   output logic [DATA_WIDTH-1:0] ram_write_data,
   output logic                  ram_wren,
   input  logic [DATA_WIDTH-1:0] ram_data,
   output logic                  busy
`ifdef MEM_ARBITER_PERF_COUNTER_EN
   ,
   input  logic                  perf_clear,
   output logic [31:0]           cpu_wait_cycles
`endif
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_RESP  = 2'd2
   } state_t;

   typedef enum logic {
      OWN_CPU = 1'b0,
      OWN_LDR = 1'b1
   } owner_t;

   state_t                  state_q, state_d;
   owner_t                  owner_q, owner_d;
   logic                    op_we_q, op_we_d;
   logic [ADDR_WIDTH-1:0]   ram_address_q, ram_address_d;
   logic [DATA_WIDTH-1:0]   ram_write_data_q, ram_write_data_d;
   logic                    ram_wren_q, ram_wren_d;
   logic                    cpu_ack_q, cpu_ack_d;
   logic                    ldr_ack_q, ldr_ack_d;
   logic [DATA_WIDTH-1:0]   cpu_read_data_q, cpu_read_data_d;
   logic [DATA_WIDTH-1:0]   ldr_read_data_q, ldr_read_data_d;

   // A requester whose ack is being delivered this cycle is not re-served;
   // this also hands the slot to the loader whenever the CPU is being acked.
   logic cpu_eligible;
   logic ldr_eligible;
   assign cpu_eligible = cpu_req & ~cpu_ack_q;
   assign ldr_eligible = ldr_req & ~ldr_ack_q;

   // State and datapath registers; reset abandons any access in flight.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q          <= ST_IDLE;
         owner_q          <= OWN_CPU;
         op_we_q          <= 1'b0;
         ram_address_q    <= '0;
         ram_write_data_q <= '0;
         ram_wren_q       <= 1'b0;
         cpu_ack_q        <= 1'b0;
         ldr_ack_q        <= 1'b0;
         cpu_read_data_q  <= '0;
         ldr_read_data_q  <= '0;
      end else begin
         state_q          <= state_d;
         owner_q          <= owner_d;
         op_we_q          <= op_we_d;
         ram_address_q    <= ram_address_d;
         ram_write_data_q <= ram_write_data_d;
         ram_wren_q       <= ram_wren_d;
         cpu_ack_q        <= cpu_ack_d;
         ldr_ack_q        <= ldr_ack_d;
         cpu_read_data_q  <= cpu_read_data_d;
         ldr_read_data_q  <= ldr_read_data_d;
      end
   end

   // Next-state: fixed-priority grant in IDLE, one ISSUE cycle, one RESP cycle.
   always_comb begin
      state_d          = state_q;
      owner_d          = owner_q;
      op_we_d          = op_we_q;
      ram_address_d    = ram_address_q;
      ram_write_data_d = ram_write_data_q;
      ram_wren_d       = ram_wren_q;
      cpu_ack_d        = 1'b0;
      ldr_ack_d        = 1'b0;
      cpu_read_data_d  = cpu_read_data_q;
      ldr_read_data_d  = ldr_read_data_q;

      unique case (state_q)
         ST_IDLE: begin
            if (cpu_eligible) begin
               owner_d          = OWN_CPU;
               op_we_d          = cpu_we;
               ram_address_d    = cpu_address;
               ram_write_data_d = cpu_write_data;
               ram_wren_d       = cpu_we;
               state_d          = ST_ISSUE;
            end else if (ldr_eligible) begin
               owner_d          = OWN_LDR;
               op_we_d          = ldr_we;
               ram_address_d    = ldr_address;
               ram_write_data_d = ldr_write_data;
               ram_wren_d       = ldr_we;
               state_d          = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            // RAM samples address/data/wren at the end of this cycle.
            ram_wren_d = 1'b0;
            state_d    = ST_RESP;
         end
         ST_RESP: begin
            // Writes leave the owner's read_data untouched.
            if (owner_q == OWN_CPU) begin
               cpu_ack_d = 1'b1;
               if (!op_we_q) cpu_read_data_d = ram_data;
            end else begin
               ldr_ack_d = 1'b1;
               if (!op_we_q) ldr_read_data_d = ram_data;
            end
            state_d = ST_IDLE;
         end
         default: begin
            state_d    = ST_IDLE;
            ram_wren_d = 1'b0;
         end
      endcase
   end

   assign cpu_ack        = cpu_ack_q;
   assign ldr_ack        = ldr_ack_q;
   assign cpu_read_data  = cpu_read_data_q;
   assign ldr_read_data  = ldr_read_data_q;
   assign ram_address    = ram_address_q;
   assign ram_write_data = ram_write_data_q;
   assign ram_wren       = ram_wren_q;
   assign busy           = (state_q != ST_IDLE);
   assign cpu_stall      = cpu_req & ~cpu_ack_q;

`ifdef MEM_ARBITER_PERF_COUNTER_EN
   logic [31:0] cpu_wait_q;

   // Saturating count of CPU stall cycles; clear wins over increment.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cpu_wait_q <= '0;
      end else if (perf_clear) begin
         cpu_wait_q <= '0;
      end else if (cpu_stall && (cpu_wait_q != 32'hFFFF_FFFF)) begin
         cpu_wait_q <= cpu_wait_q + 32'd1;
      end
   end

   assign cpu_wait_cycles = cpu_wait_q;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
module tb_mem_arbiter;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        cpu_req, cpu_we;
   logic [14:0] cpu_address;
   logic [31:0] cpu_write_data;
   logic        cpu_ack;
   logic [31:0] cpu_read_data;
   logic        cpu_stall;
   logic        ldr_req, ldr_we;
   logic [14:0] ldr_address;
   logic [31:0] ldr_write_data;
   logic        ldr_ack;
   logic [31:0] ldr_read_data;
   logic [14:0] ram_address;
   logic [31:0] ram_write_data;
   logic        ram_wren;
   logic [31:0] ram_data;
   logic        busy;
`ifdef MEM_ARBITER_PERF_COUNTER_EN
   logic        perf_clear;
   logic [31:0] cpu_wait_cycles;
`endif

   int checks = 0;
   int errors = 0;

   logic [31:0] mem [0:32767];

   always #5 clk = ~clk;

   mem_arbiter #(.ADDR_WIDTH(15), .DATA_WIDTH(32)) dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .cpu_req        (cpu_req),
      .cpu_we         (cpu_we),
      .cpu_address    (cpu_address),
      .cpu_write_data (cpu_write_data),
      .cpu_ack        (cpu_ack),
      .cpu_read_data  (cpu_read_data),
      .cpu_stall      (cpu_stall),
      .ldr_req        (ldr_req),
      .ldr_we         (ldr_we),
      .ldr_address    (ldr_address),
      .ldr_write_data (ldr_write_data),
      .ldr_ack        (ldr_ack),
      .ldr_read_data  (ldr_read_data),
      .ram_address    (ram_address),
      .ram_write_data (ram_write_data),
      .ram_wren       (ram_wren),
      .ram_data       (ram_data),
      .busy           (busy)
`ifdef MEM_ARBITER_PERF_COUNTER_EN
      ,
      .perf_clear     (perf_clear),
      .cpu_wait_cycles(cpu_wait_cycles)
`endif
   );

   // Single-port synchronous RAM model
   always @(posedge clk) begin
      if (ram_wren) mem[ram_address] <= ram_write_data;
      ram_data <= mem[ram_address];
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Isolated access from one port; entered and left at posedge+1.
   task automatic access(input bit is_ldr, input bit we, input logic [14:0] addr,
                         input logic [31:0] wd, input logic [31:0] exp_rd, input string tag);
      if (!is_ldr) begin
         cpu_req = 1'b1; cpu_we = we; cpu_address = addr; cpu_write_data = wd;
      end else begin
         ldr_req = 1'b1; ldr_we = we; ldr_address = addr; ldr_write_data = wd;
      end
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         if (!is_ldr) begin
            chk1({tag, "_cpu_ack"}, cpu_ack, c == 3);
            chk1({tag, "_cpu_stall"}, cpu_stall, c < 3);
         end else begin
            chk1({tag, "_ldr_ack"}, ldr_ack, c == 3);
         end
         chk1({tag, "_wren"}, ram_wren, we && (c == 1));
         chk1({tag, "_busy"}, busy, (c == 1) || (c == 2));
         if (c == 1) chk({tag, "_ram_addr"}, {17'd0, ram_address}, {17'd0, addr});
         if (c == 3) chk({tag, "_rdata"}, is_ldr ? ldr_read_data : cpu_read_data, exp_rd);
         tick();
      end
      if (!is_ldr) cpu_req = 1'b0; else ldr_req = 1'b0;
   endtask

   initial begin
      reset_n = 1'b0;
      cpu_req = 1'b0; cpu_we = 1'b0; cpu_address = '0; cpu_write_data = '0;
      ldr_req = 1'b0; ldr_we = 1'b0; ldr_address = '0; ldr_write_data = '0;
`ifdef MEM_ARBITER_PERF_COUNTER_EN
      perf_clear = 1'b0;
`endif
      mem[15'h0010] = 32'hDEADBEEF;
      mem[15'h0001] = 32'h11111111;
      mem[15'h0002] = 32'h22222222;
      mem[15'h0005] = 32'h55555555;
      mem[15'h0006] = 32'h66666666;
      mem[15'h0030] = 32'hAAAAAAAA;

      // Reset state
      tick(); tick();
      @(negedge clk);
      chk1("rst_cpu_ack", cpu_ack, 1'b0);
      chk1("rst_ldr_ack", ldr_ack, 1'b0);
      chk("rst_cpu_rdata", cpu_read_data, 32'h0);
      chk("rst_ldr_rdata", ldr_read_data, 32'h0);
      chk("rst_ram_addr", {17'd0, ram_address}, 32'h0);
      chk("rst_ram_wdata", ram_write_data, 32'h0);
      chk1("rst_wren", ram_wren, 1'b0);
      chk1("rst_busy", busy, 1'b0);
      chk1("rst_stall", cpu_stall, 1'b0);
      tick();
      reset_n = 1'b1;
      tick();

      // CPU read alone
      access(1'b0, 1'b0, 15'h0010, 32'h0, 32'hDEADBEEF, "t1");

      // Loader write, then CPU read of the same word
      access(1'b1, 1'b1, 15'h0020, 32'h12345678, 32'h0, "t2w");
      @(negedge clk);
      chk("t2_mem", mem[15'h0020], 32'h12345678);
      tick();
      access(1'b0, 1'b0, 15'h0020, 32'h0, 32'h12345678, "t2r");
      tick();

      // Simultaneous requests: CPU first, loader granted in the CPU ack cycle
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_address = 15'h0001;
      ldr_req = 1'b1; ldr_we = 1'b0; ldr_address = 15'h0002;
      for (int c = 0; c < 7; c++) begin
         @(negedge clk);
         chk1("t3_cpu_ack", cpu_ack, c == 3);
         chk1("t3_ldr_ack", ldr_ack, c == 6);
         if (c == 3) begin
            chk("t3_cpu_rdata", cpu_read_data, 32'h11111111);
            chk("t3_ldr_rdata_hold", ldr_read_data, 32'h0);
         end
         if (c == 4) chk("t3_ram_addr_ldr", {17'd0, ram_address}, 32'h2);
         if (c == 6) chk("t3_ldr_rdata", ldr_read_data, 32'h22222222);
         tick();
         if (c == 3) cpu_req = 1'b0;
         if (c == 6) ldr_req = 1'b0;
      end
      tick();

      // CPU holds req; loader arrives at cycle 1 -> CPU, LDR, CPU
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_address = 15'h0005;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         chk1("t4_cpu_ack", cpu_ack, (c == 3) || (c == 9));
         chk1("t4_ldr_ack", ldr_ack, c == 6);
         if (c == 4) chk("t4_ram_addr_ldr", {17'd0, ram_address}, 32'h6);
         if (c == 6) chk("t4_ldr_rdata", ldr_read_data, 32'h66666666);
         if (c == 9) chk("t4_cpu_rdata", cpu_read_data, 32'h55555555);
         tick();
         if (c == 0) begin
            ldr_req = 1'b1; ldr_we = 1'b0; ldr_address = 15'h0006;
         end
         if (c == 6) ldr_req = 1'b0;
         if (c == 9) cpu_req = 1'b0;
      end
      tick();

      // Reset during ISSUE of a CPU write
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_address = 15'h0030; cpu_write_data = 32'hBBBBBBBB;
      tick();
      chk1("t5_wren_issue", ram_wren, 1'b1);
      #2;
      reset_n = 1'b0;
      cpu_req = 1'b0; cpu_we = 1'b0;
      #1;
      chk1("t5_wren_rst", ram_wren, 1'b0);
      chk1("t5_busy_rst", busy, 1'b0);
      chk1("t5_ack_rst", cpu_ack, 1'b0);
      tick();
      @(negedge clk);
      chk("t5_mem_kept", mem[15'h0030], 32'hAAAAAAAA);
      chk1("t5_no_ack", cpu_ack, 1'b0);
      tick();
      reset_n = 1'b1;
      tick();
      access(1'b0, 1'b0, 15'h0030, 32'h0, 32'hAAAAAAAA, "t5r");
      tick();

`ifdef MEM_ARBITER_PERF_COUNTER_EN
      // Stall-cycle counter: three isolated reads, then clear
      perf_clear = 1'b1;
      tick();
      perf_clear = 1'b0;
      for (int i = 0; i < 3; i++) begin
         access(1'b0, 1'b0, 15'h0010, 32'h0, 32'hDEADBEEF, "t6");
         tick();
      end
      @(negedge clk);
      chk("t6_wait_cycles", cpu_wait_cycles, 32'd9);
      tick();
      perf_clear = 1'b1;
      tick();
      perf_clear = 1'b0;
      @(negedge clk);
      chk("t6_wait_clear", cpu_wait_cycles, 32'd0);
      tick();
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
